data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Word-addressed data memory with configurable wait states and a stall handshake. It responds to the `mem_read` / `mem_write` strobes the processor's control path decodes from the opcode. It sits in the MEM stage of the single-cycle datapath. It holds the processor via `stall` until each load or store completes, so the datapath can be exercised against slow-memory timing.

## Interface
- `ADDR_WIDTH`, default 8: word-address bits; depth = 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 32: word width.
- `WAIT_STATES`, default 2: BUSY cycles per access; legal range 0..15.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `mem_read`  in  1  load request; held by the processor until `stall` is low.
- `mem_write`  in  1  store request; held by the processor until `stall` is low.
- `addr`  in  32  byte address; the word index is `addr[ADDR_WIDTH+1:2]`.
- `write_data`  in  DATA_WIDTH  store data.
- `read_data`  out  DATA_WIDTH  registered load result.
- `stall`  out  1  combinational; high while an access is pending.
- `misaligned`  out  1  high for the completion cycle of an access with `addr[1:0]` ≠ 0.

## Operation
- **States:** IDLE, BUSY, DONE. A 4-bit wait counter `wcnt` tracks BUSY cycles.
- **IDLE, request seen** (`mem_read` | `mem_write`):
  - Latch op, word index, `write_data`, and `addr[1:0]`≠0.
  - If both strobes are high, store wins; it is treated as a write.
  - WAIT_STATES > 0: go to BUSY with `wcnt` = WAIT_STATES−1.
  - WAIT_STATES = 0: perform the access and go to DONE.
- **BUSY:**
  - If `wcnt` ≠ 0: decrement `wcnt`.
  - If `wcnt` = 0: perform the access and go to DONE.
  - Inputs are ignored; only the latched values are used.
- **Perform access** (on the edge entering DONE):
  - Aligned write: update `mem[index]`.
  - Aligned read: load `read_data` ← `mem[index]`.
  - Misaligned: no array write; `read_data` unchanged.
- **DONE:** one cycle, unconditional return to IDLE.
- **Stall:** `stall` = (IDLE & (`mem_read` | `mem_write`)) | BUSY.
  - `stall` is low in DONE; the processor advances at the end of DONE.
  - A request visible in DONE is the one just completed and is not restarted.
- **Request dropped mid-BUSY** (protocol violation): the access still completes from latched values.
- **Address wrap:** `addr` bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo depth.
- **read_data hold:** `read_data` holds its value across writes and idle cycles until the next aligned read completes.
- **Reset (`rst_n` low, any time):**
  - State → IDLE, `wcnt` = 0, `read_data` = 0, `misaligned` = 0.
  - A pending write is dropped; the array is not modified.
  - Array contents are not reset.
- **Reset output values:** `read_data` = 0, `misaligned` = 0. `stall` follows the request inputs combinationally (IDLE).

## Timing
- **Access length:** WAIT_STATES+2 cycles per access (IDLE request cycle, WAIT_STATES BUSY cycles, DONE).
- **Stall duration:** `stall` is high for exactly WAIT_STATES+1 cycles per access.
- **Data availability:** `read_data` is valid from the first cycle of DONE until the next aligned read.
- **Back-to-back accesses:** there is one IDLE cycle between them, which is the next request's stall cycle, so there is no dead cycle beyond the formula.
- **Combinational paths:** only `stall` depends combinationally on inputs (the strobes). `read_data` and `misaligned` are registers.

## Test plan
- **Write then read, WAIT_STATES=2:**
  - Stimulus: store 0xDEADBEEF at `addr` 0x10, then load `addr` 0x10.
  - Required: `stall` high 3 cycles for each access; `read_data` = 0xDEADBEEF in the load's DONE cycle.
- **WAIT_STATES=0, back-to-back:**
  - Stimulus: store 0x1 at 0x0, store 0x2 at 0x4, load 0x4, then load 0x0.
  - Required: each access takes 2 cycles with `stall` high for 1; loads return 0x2, then 0x1.
- **Misaligned store:**
  - Stimulus: store 0x55 at 0x13, then load 0x10.
  - Required: `misaligned` = 1 for the store's DONE cycle only; the load returns the prior value at 0x10.
- **Wrap-around, ADDR_WIDTH=8:**
  - Stimulus: store 0xA5A5 at byte `addr` 0x400.
  - Required: a load from 0x0 returns 0xA5A5.
- **Reset mid-write:**
  - Stimulus: `rst_n` low during BUSY of a store of 0x77 to 0x20, after a prior store of 0x11 to 0x20.
  - Required: `read_data` = 0, `stall` low with strobes low; a later load of 0x20 returns 0x11.
- **Simultaneous strobes:**
  - Stimulus: `mem_read`=`mem_write`=1 with `write_data`=0x9 at 0x8.
  - Required: a write is performed; `read_data` is unchanged; a later load of 0x8 returns 0x9.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with configurable wait states and a stall handshake.
// Holds the processor via stall until each load or store reaches its DONE cycle.
module data_mem_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  stall,
  output logic                  misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                  state;
  logic [3:0]              wcnt;
  logic                    lat_write;
  logic [ADDR_WIDTH-1:0]   lat_idx;
  logic [DATA_WIDTH-1:0]   lat_data;
  logic                    lat_mis;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    req;
  logic                    acc_go;
  logic                    acc_write;
  logic [ADDR_WIDTH-1:0]   acc_idx;
  logic [DATA_WIDTH-1:0]   acc_data;
  logic                    acc_mis;
  logic                    unused_addr_bits;

  // Upper address bits are deliberately dropped so accesses wrap modulo depth.
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  assign req   = mem_read | mem_write;
  assign stall = ((state == IDLE) && req) || (state == BUSY);

  // With zero wait states the access is performed straight from the live inputs,
  // otherwise from the values latched in IDLE.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it
    // unassigned, which would otherwise infer a latch.
    acc_go    = 1'b0;
    acc_write = lat_write;
    acc_idx   = lat_idx;
    acc_data  = lat_data;
    acc_mis   = lat_mis;
    unique case (state)
      IDLE: begin
        acc_write = mem_write;
        acc_idx   = addr[ADDR_WIDTH+1:2];
        acc_data  = write_data;
        acc_mis   = |addr[1:0];
        acc_go    = req && (WAIT_STATES == 0);
      end
      BUSY:    acc_go = (wcnt == 4'd0);
      default: acc_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wcnt       <= 4'd0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_data   <= '0;
      lat_mis    <= 1'b0;
      read_data  <= '0;
      misaligned <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      misaligned <= 1'b0;
      if (acc_go) begin
        misaligned <= acc_mis;
        if (!acc_write && !acc_mis) read_data <= mem[acc_idx];
      end

      unique case (state)
        IDLE: begin
          if (req) begin
            lat_write <= mem_write;
            lat_idx   <= addr[ADDR_WIDTH+1:2];
            lat_data  <= write_data;
            lat_mis   <= |addr[1:0];
            if (WAIT_STATES == 0) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              wcnt  <= WCNT_INIT;
            end
          end
        end
        BUSY: begin
          if (wcnt != 4'd0) wcnt  <= wcnt - 4'd1;
          else              state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset branch; clearing it would turn the RAM into flops.
  // rst_n still gates the enable so a store caught by reset never lands.
  always_ff @(posedge clk) begin
    if (rst_n && acc_go && acc_write && !acc_mis) mem[acc_idx] <= acc_data;
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench: one instance with WAIT_STATES=2, one with WAIT_STATES=0,
// a reference memory model and per-instance scoreboards of expected completions.
module tb_data_mem_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] rd;
    logic          mis;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd_s   [2];
  logic          wr_s   [2];
  logic [31:0]   addr_s [2];
  logic [DW-1:0] wd_s   [2];
  logic [DW-1:0] rdata  [2];
  logic          stall  [2];
  logic          mis    [2];

  int            n_vec = 0;
  int            n_err = 0;

  logic [DW-1:0] mm      [2][256];
  logic [DW-1:0] last_rd [2];
  exp_t          q0 [$];
  exp_t          q1 [$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(2)) u_dut_ws2 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .addr(addr_s[0]), .write_data(wd_s[0]), .read_data(rdata[0]),
    .stall(stall[0]), .misaligned(mis[0])
  );

  data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0)) u_dut_ws0 (
    .clk(clk), .rst_n(rst_n), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .addr(addr_s[1]), .write_data(wd_s[1]), .read_data(rdata[1]),
    .stall(stall[1]), .misaligned(mis[1])
  );

  // Starts at a falling edge, holds the request until stall drops (or after one
  // cycle when drop is set), then checks the DONE cycle against the scoreboard.
  task automatic access(input int d, input logic w, input logic r,
                        input logic [31:0] a, input logic [DW-1:0] data,
                        input bit drop);
    int         cyc;
    int         ws;
    exp_t       e;
    logic [7:0] idx;
    logic       m;
    ws  = (d == 0) ? 2 : 0;
    idx = a[AW+1:2];
    m   = (a[1:0] != 2'b00);
    if (!m && w)       mm[d][idx] = data;
    else if (!m && r)  last_rd[d] = mm[d][idx];
    e.rd  = last_rd[d];
    e.mis = m;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);

    wr_s[d] = w; rd_s[d] = r; addr_s[d] = a; wd_s[d] = data;
    #1;
    cyc = 0;
    while (stall[d] === 1'b1 && cyc < 40) begin
      n_vec++;
      if (mis[d] !== 1'b0) begin
        n_err++;
        $display("FAIL misaligned_while_stalled dut%0d: got %b expected 0", d, mis[d]);
      end
      cyc++;
      @(posedge clk);
      #1;
      if (drop) begin wr_s[d] = 1'b0; rd_s[d] = 1'b0; end
      @(negedge clk);
      #1;
    end

    if (d == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    n_vec++;
    if (cyc !== ws + 1) begin
      n_err++;
      $display("FAIL stall_cycles dut%0d addr %h: got %0d expected %0d", d, a, cyc, ws + 1);
    end
    n_vec++;
    if (rdata[d] !== e.rd) begin
      n_err++;
      $display("FAIL read_data dut%0d addr %h: got %h expected %h", d, a, rdata[d], e.rd);
    end
    n_vec++;
    if (mis[d] !== e.mis) begin
      n_err++;
      $display("FAIL misaligned_done dut%0d addr %h: got %b expected %b", d, a, mis[d], e.mis);
    end
    wr_s[d] = 1'b0; rd_s[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd_s[d] = 1'b0; wr_s[d] = 1'b0; addr_s[d] = '0; wd_s[d] = '0; last_rd[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdata[d] !== '0 || mis[d] !== 1'b0 || stall[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got rd=%h mis=%b stall=%b expected 0/0/0",
                 d, rdata[d], mis[d], stall[d]);
      end
    end
    wr_s[0] = 1'b1;
    #1;
    n_vec++;
    if (stall[0] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_follows_strobe_in_reset: got %b expected 1", stall[0]);
    end
    wr_s[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    access(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
  endtask

  task automatic test_back_to_back;
    access(1, 1'b1, 1'b0, 32'h0, 32'h1, 1'b0);
    access(1, 1'b1, 1'b0, 32'h4, 32'h2, 1'b0);
    access(1, 1'b0, 1'b1, 32'h4, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_misaligned;
    access(0, 1'b1, 1'b0, 32'h13, 32'h55, 1'b0);
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0);
    access(1, 1'b0, 1'b1, 32'h5, 32'h0, 1'b0);
  endtask

  task automatic test_wrap;
    access(0, 1'b1, 1'b0, 32'h400, 32'hA5A5, 1'b0);
    access(0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'hFFC, 32'h3C3C, 1'b0);
    access(1, 1'b0, 1'b1, 32'h3FC, 32'h0, 1'b0);
  endtask

  task automatic test_simultaneous;
    access(0, 1'b1, 1'b1, 32'h8, 32'h9, 1'b0);
    access(0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0);
  endtask

  task automatic test_dropped_request;
    access(0, 1'b1, 1'b0, 32'h30, 32'hCAFE, 1'b1);
    access(0, 1'b0, 1'b1, 32'h30, 32'h0, 1'b1);
  endtask

  task automatic test_hold;
    access(0, 1'b1, 1'b0, 32'h44, 32'h1234, 1'b0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdata[d] !== last_rd[d]) begin
        n_err++;
        $display("FAIL read_data_hold dut%0d: got %h expected %h", d, rdata[d], last_rd[d]);
      end
    end
  endtask

  task automatic test_reset_mid_write;
    access(0, 1'b1, 1'b0, 32'h20, 32'h11, 1'b0);
    wr_s[0] = 1'b1; addr_s[0] = 32'h20; wd_s[0] = 32'h77;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    wr_s[0] = 1'b0;
    #1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    for (int d = 0; d < 2; d++) begin
      n_vec++;
      if (rdata[d] !== '0 || stall[d] !== 1'b0 || mis[d] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_write dut%0d: got rd=%h stall=%b mis=%b expected 0/0/0",
                 d, rdata[d], stall[d], mis[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    access(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_misaligned();
    test_wrap();
    test_simultaneous();
    test_dropped_request();
    test_hold();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
